capture_sequencer: RTL and testbench
====================================

// Module: capture_sequencer
// PURPOSE
//  Frame sequencer in front of toy_correlator on the signal clock.
//  - Samples the antenna I/Q bus every cycle and packs it into correlator frames of
//    programmable length, driving sig_valid/sig_last with a one-beat holding register.
//  - Repeats frames N times or until aborted; counts frames and overrun (dropped) samples.
//  - Replaces testbench-style start/count logic with a synthesizable controller.
// PARAMETERS
//  WIDTH    4   antennas; width of each of the I and Q buses
//  LBITS    10  frame-length counter width
//  FBITS    8   frame-count width
//  GAP_CYC  2   idle cycles, valid low, between consecutive frames (>=1)
// PORTS
//  sig_clock     in   1      signal/sample clock; the only clock
//  areset_n      in   1      asynchronous, active-low reset
//  ctl_start_i   in   1      1-cycle start pulse
//  ctl_abort_i   in   1      1-cycle abort pulse
//  ctl_length_i  in   LBITS  samples per frame L; latched at start
//  ctl_frames_i  in   FBITS  frames N; latched at start; 0 = run until abort
//  ant_idata_i   in   WIDTH  radio I bits, one new sample every cycle
//  ant_qdata_i   in   WIDTH  radio Q bits
//  sig_valid_o   out  1      beat valid to correlator
//  sig_last_o    out  1      final beat of the frame
//  sig_idata_o   out  WIDTH  beat I data
//  sig_qdata_o   out  WIDTH  beat Q data
//  sig_ready_i   in   1      correlator ready
//  ctl_busy_o    out  1      high in any state other than IDLE
//  ctl_done_o    out  1      1-cycle pulse when a run ends
//  ctl_frame_o   out  FBITS  frames completed this run; wraps at 2^FBITS
//  ctl_drops_o   out  16     samples dropped this run; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE.
//  Reset is asynchronous: asserting areset_n low mid-frame clears outputs immediately.
//  Handshake: a beat is accepted when sig_valid_o & sig_ready_i.
//    - Data and last hold stable while valid & !ready.
//    - Valid drops only after acceptance.
//  Latency: a sample on ant_* in cycle t appears on sig_*data_o in cycle t+1.
//  States and transitions:
//   IDLE   : start with L!=0 -> latch L and N, clear frame and drop counters -> ARM.
//            start with L==0 -> ignored.
//   ARM    : valid low. Go to STREAM on the first cycle sig_ready_i=1.
//   STREAM : load cycle is any cycle with (!sig_valid_o || sig_ready_i).
//            - Each load cycle registers the current sample as a beat, valid=1.
//            - The beat with index L-1 carries last=1.
//            - A sample arriving while the held beat is unaccepted is dropped; drops +1.
//            - Once the last beat is loaded, no further loads occur; those samples are
//              not counted as drops.
//            - On acceptance of the last beat, frame +1.
//              If N!=0 and frame==N -> DONE, else -> GAP.
//   GAP    : valid low for GAP_CYC cycles -> STREAM; beat index restarts at 0.
//   DONE   : ctl_done_o=1 for exactly one cycle -> IDLE.
//  L==1: every beat is last=1.
//  Abort:
//   - In ARM or GAP -> DONE on the next cycle.
//   - In STREAM: the next loaded beat is forced last=1 (short frame); its acceptance
//     increments frame, then -> DONE.
//   - In STREAM when the last beat is already loaded: that beat completes normally, then
//     -> DONE.
//  Start while busy: ignored. Start and abort together in IDLE: abort wins, nothing starts.
//  ctl_length_i and ctl_frames_i changes after start have no effect until the next run.
// STRUCTURE
//  Package capture_pkg: state encoding (IDLE, ARM, STREAM, GAP, DONE), DROP_BITS=16,
//  function sat_inc.
//  Sub-module sat_counter (width param, clear, inc, saturate) for ctl_drops_o.
//  Everything else stays inline.
// TESTING
//  1 L=4, N=2, ready=1: two 4-beat frames, last on beats 3 and 7, a 2-cycle valid gap
//    between frames; done pulses once; frame=2, drops=0.
//  2 L=8, N=1, ready low 3 cycles mid-frame: data held stable; drops=3; 8 beats accepted;
//    last on the 8th.
//  3 N=0, L=5, abort after 7 accepted beats: 2nd frame closes at 3 beats with last=1;
//    frame=2; done pulses; busy falls.
//  4 start with L=0 -> busy stays 0; start while busy -> ignored; latched L, N unchanged.
//  5 reset asserted mid-STREAM: valid, last, busy, frame, drops read 0 before the next
//    clock edge; run restarts cleanly after release.
//  6 ready held 0 for 70000 cycles in STREAM: drops saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: shared definitions for the capture sequencer.
//   state_e    - controller state encoding
//   DROP_BITS  - width of the dropped-sample counter
//   sat_inc    - saturating increment used by the drop counter
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_STREAM,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int DROP_BITS = 16;

  // Increment that sticks at max_value instead of wrapping. Operates on 32 bits
  // so counters of any width up to 32 can share it.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that saturates at all-ones.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clear_i  in   synchronous clear (wins over inc_i)
//   inc_i    in   count enable
//   count_o  out  current count
module sat_counter
  import capture_pkg::*;
#(
  parameter int WIDTH = DROP_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX_VALUE = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: assign the default before any branch so every path drives cnt_d;
    // a missing assignment in combinational logic infers a latch.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = WIDTH'(sat_inc(32'(cnt_q), 32'(MAX_VALUE)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: packs the per-cycle antenna I/Q samples into correlator
// frames of programmable length, repeats frames N times (or until aborted), and
// counts completed frames and dropped samples.
// Ports:
//   sig_clock     in   sample clock (only clock)
//   areset_n      in   asynchronous active-low reset
//   ctl_start_i   in   start pulse; latches ctl_length_i / ctl_frames_i
//   ctl_abort_i   in   abort pulse
//   ctl_length_i  in   samples per frame L (0 = start ignored)
//   ctl_frames_i  in   frames per run N (0 = until abort)
//   ant_idata_i   in   antenna I sample
//   ant_qdata_i   in   antenna Q sample
//   sig_valid_o   out  beat valid
//   sig_last_o    out  final beat of frame
//   sig_idata_o   out  beat I data
//   sig_qdata_o   out  beat Q data
//   sig_ready_i   in   correlator ready
//   ctl_busy_o    out  controller not idle
//   ctl_done_o    out  one-cycle end-of-run pulse
//   ctl_frame_o   out  frames completed this run (wraps)
//   ctl_drops_o   out  samples dropped this run (saturates)
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LBITS   = 10,
  parameter int FBITS   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic                 sig_clock,
  input  logic                 areset_n,
  input  logic                 ctl_start_i,
  input  logic                 ctl_abort_i,
  input  logic [LBITS-1:0]     ctl_length_i,
  input  logic [FBITS-1:0]     ctl_frames_i,
  input  logic [WIDTH-1:0]     ant_idata_i,
  input  logic [WIDTH-1:0]     ant_qdata_i,
  output logic                 sig_valid_o,
  output logic                 sig_last_o,
  output logic [WIDTH-1:0]     sig_idata_o,
  output logic [WIDTH-1:0]     sig_qdata_o,
  input  logic                 sig_ready_i,
  output logic                 ctl_busy_o,
  output logic                 ctl_done_o,
  output logic [FBITS-1:0]     ctl_frame_o,
  output logic [DROP_BITS-1:0] ctl_drops_o
);

  localparam int GBITS = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e             state_q, state_d;
  logic [LBITS-1:0]   len_q, len_d;
  logic [FBITS-1:0]   frames_q, frames_d;
  logic [FBITS-1:0]   frame_q, frame_d;
  logic [LBITS-1:0]   beat_q, beat_d;
  logic [GBITS-1:0]   gap_q, gap_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   idata_q, idata_d;
  logic [WIDTH-1:0]   qdata_q, qdata_d;
  // The frame's last beat has been loaded and is waiting for acceptance.
  logic               last_loaded_q, last_loaded_d;
  // Abort seen while streaming: close the frame early, then end the run.
  logic               abort_pend_q, abort_pend_d;

  logic               accept;
  logic               load;
  logic               force_last;
  logic               load_last;
  logic               drop_clear;
  logic               drop_inc;
  logic [FBITS-1:0]   frame_inc;

  assign accept    = valid_q & sig_ready_i;
  assign frame_inc = frame_q + FBITS'(1);
  assign load_last = force_last || (beat_q == len_q - LBITS'(1));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    frames_d      = frames_q;
    frame_d       = frame_q;
    beat_d        = beat_q;
    gap_d         = gap_q;
    valid_d       = valid_q;
    last_d        = last_q;
    idata_d       = idata_q;
    qdata_d       = qdata_q;
    last_loaded_d = last_loaded_q;
    abort_pend_d  = abort_pend_q;
    load          = 1'b0;
    force_last    = 1'b0;
    drop_clear    = 1'b0;
    drop_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Abort beats start; a zero length never starts a run.
        if (ctl_start_i && !ctl_abort_i && (ctl_length_i != '0)) begin
          len_d         = ctl_length_i;
          frames_d      = ctl_frames_i;
          frame_d       = '0;
          beat_d        = '0;
          last_loaded_d = 1'b0;
          abort_pend_d  = 1'b0;
          drop_clear    = 1'b1;
          state_d       = ST_ARM;
        end
      end

      ST_ARM: begin
        if (ctl_abort_i) begin
          state_d = ST_DONE;
        end else if (sig_ready_i) begin
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (ctl_abort_i) begin
          abort_pend_d = 1'b1;
        end
        if (last_loaded_q) begin
          // Frame fully loaded: hold the last beat, ignore incoming samples.
          if (accept) begin
            valid_d       = 1'b0;
            last_d        = 1'b0;
            last_loaded_d = 1'b0;
            frame_d       = frame_inc;
            if (abort_pend_q || ctl_abort_i ||
                ((frames_q != '0) && (frame_inc == frames_q))) begin
              state_d = ST_DONE;
            end else begin
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end
        end else if (!valid_q || sig_ready_i) begin
          load       = 1'b1;
          force_last = abort_pend_q || ctl_abort_i;
        end else begin
          drop_inc = 1'b1;
        end
      end

      ST_GAP: begin
        // The final gap cycle loads beat 0, so valid is low for exactly
        // GAP_CYC cycles between frames.
        if (ctl_abort_i) begin
          state_d = ST_DONE;
        end else if (gap_q == GBITS'(GAP_CYC - 1)) begin
          load    = 1'b1;
          state_d = ST_STREAM;
        end else begin
          gap_d = gap_q + GBITS'(1);
        end
      end

      ST_DONE: begin
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      valid_d       = 1'b1;
      idata_d       = ant_idata_i;
      qdata_d       = ant_qdata_i;
      last_d        = load_last;
      last_loaded_d = load_last;
      beat_d        = load_last ? '0 : beat_q + LBITS'(1);
    end
  end

  always_ff @(posedge sig_clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      frames_q      <= '0;
      frame_q       <= '0;
      beat_q        <= '0;
      gap_q         <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      idata_q       <= '0;
      qdata_q       <= '0;
      last_loaded_q <= 1'b0;
      abort_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      frames_q      <= frames_d;
      frame_q       <= frame_d;
      beat_q        <= beat_d;
      gap_q         <= gap_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
      idata_q       <= idata_d;
      qdata_q       <= qdata_d;
      last_loaded_q <= last_loaded_d;
      abort_pend_q  <= abort_pend_d;
    end
  end

  sat_counter #(
    .WIDTH(DROP_BITS)
  ) u_drops (
    .clk    (sig_clock),
    .rst_n  (areset_n),
    .clear_i(drop_clear),
    .inc_i  (drop_inc),
    .count_o(ctl_drops_o)
  );

  assign sig_valid_o = valid_q;
  assign sig_last_o  = last_q;
  assign sig_idata_o = idata_q;
  assign sig_qdata_o = qdata_q;
  assign ctl_busy_o  = (state_q != ST_IDLE);
  assign ctl_done_o  = (state_q == ST_DONE);
  assign ctl_frame_o = frame_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer (WIDTH=4, LBITS=10, FBITS=8, GAP_CYC=2).
module tb_capture_sequencer;

  logic        sig_clock = 1'b0;
  logic        areset_n;
  logic        ctl_start_i;
  logic        ctl_abort_i;
  logic [9:0]  ctl_length_i;
  logic [7:0]  ctl_frames_i;
  logic [3:0]  ant_idata_i;
  logic [3:0]  ant_qdata_i;
  logic        sig_valid_o;
  logic        sig_last_o;
  logic [3:0]  sig_idata_o;
  logic [3:0]  sig_qdata_o;
  logic        sig_ready_i;
  logic        ctl_busy_o;
  logic        ctl_done_o;
  logic [7:0]  ctl_frame_o;
  logic [15:0] ctl_drops_o;

  capture_sequencer dut (
    .sig_clock   (sig_clock),
    .areset_n    (areset_n),
    .ctl_start_i (ctl_start_i),
    .ctl_abort_i (ctl_abort_i),
    .ctl_length_i(ctl_length_i),
    .ctl_frames_i(ctl_frames_i),
    .ant_idata_i (ant_idata_i),
    .ant_qdata_i (ant_qdata_i),
    .sig_valid_o (sig_valid_o),
    .sig_last_o  (sig_last_o),
    .sig_idata_o (sig_idata_o),
    .sig_qdata_o (sig_qdata_o),
    .sig_ready_i (sig_ready_i),
    .ctl_busy_o  (ctl_busy_o),
    .ctl_done_o  (ctl_done_o),
    .ctl_frame_o (ctl_frame_o),
    .ctl_drops_o (ctl_drops_o)
  );

  always #5 sig_clock = ~sig_clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         samp     = 0;
  int         s0;
  logic [7:0] acc_data[$];
  logic [31:0] last_mask;
  int         acc_n;
  int         done_n;
  int         gap_low;
  int         pend_low;
  bit         seen_valid;

  int t1_idx[4] = '{0, 3, 4, 7};
  int t1_off[4] = '{2, 5, 8, 11};
  int t2_off[8] = '{2, 3, 4, 5, 9, 10, 11, 12};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    acc_data.delete();
    last_mask  = '0;
    acc_n      = 0;
    done_n     = 0;
    gap_low    = 0;
    pend_low   = 0;
    seen_valid = 1'b0;
  endtask

  // Log what the coming edge will see, advance one cycle, drive a new sample.
  task automatic step();
    if (sig_valid_o && sig_ready_i) begin
      acc_data.push_back({sig_qdata_o, sig_idata_o});
      if (sig_last_o) last_mask |= (32'd1 << acc_n);
      acc_n++;
    end
    if (ctl_done_o) done_n++;
    if (sig_valid_o) begin
      gap_low   += pend_low;
      pend_low   = 0;
      seen_valid = 1'b1;
    end else if (seen_valid) begin
      pend_low++;
    end
    @(posedge sig_clock);
    #1;
    samp++;
    ant_idata_i = samp[3:0];
    ant_qdata_i = samp[7:4];
  endtask

  task automatic start_run(input logic [9:0] len, input logic [7:0] frames);
    ctl_length_i = len;
    ctl_frames_i = frames;
    ctl_start_i  = 1'b1;
    s0 = samp;
    step();
    ctl_start_i = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    step();
    while (ctl_busy_o && n < budget) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, ctl_busy_o, 1'b0);
  endtask

  initial begin
    areset_n     = 1'b0;
    ctl_start_i  = 1'b0;
    ctl_abort_i  = 1'b0;
    ctl_length_i = '0;
    ctl_frames_i = '0;
    ant_idata_i  = '0;
    ant_qdata_i  = '0;
    sig_ready_i  = 1'b0;
    clear_log();
    #3;
    check("rst_valid", sig_valid_o, 1'b0);
    check("rst_last",  sig_last_o,  1'b0);
    check("rst_data",  {sig_qdata_o, sig_idata_o}, 8'h00);
    check("rst_busy",  ctl_busy_o,  1'b0);
    check("rst_done",  ctl_done_o,  1'b0);
    check("rst_frame", ctl_frame_o, 8'h00);
    check("rst_drops", ctl_drops_o, 16'h0000);
    #4 areset_n = 1'b1;
    @(posedge sig_clock);
    #1;

    // 1: L=4, N=2, ready always high.
    clear_log();
    sig_ready_i = 1'b1;
    start_run(10'd4, 8'd2);
    run_until_idle("t1", 100);
    check("t1_beats", acc_n, 8);
    check("t1_last_mask", last_mask, 32'h88);
    for (int i = 0; i < 4; i++)
      check("t1_data", acc_data[t1_idx[i]], 8'(s0 + t1_off[i]));
    check("t1_gap", gap_low, 2);
    check("t1_done", done_n, 1);
    check("t1_frame", ctl_frame_o, 8'd2);
    check("t1_drops", ctl_drops_o, 16'd0);

    // 2: L=8, N=1, ready low for 3 cycles while beat 3 is held.
    clear_log();
    sig_ready_i = 1'b1;
    start_run(10'd8, 8'd1);
    repeat (5) step();
    sig_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", sig_valid_o, 1'b1);
      check("t2_hold_data", {sig_qdata_o, sig_idata_o}, 8'(s0 + 5));
      step();
    end
    sig_ready_i = 1'b1;
    run_until_idle("t2", 100);
    check("t2_beats", acc_n, 8);
    check("t2_last_mask", last_mask, 32'h80);
    for (int i = 0; i < 8; i++)
      check("t2_data", acc_data[i], 8'(s0 + t2_off[i]));
    check("t2_drops", ctl_drops_o, 16'd3);
    check("t2_frame", ctl_frame_o, 8'd1);
    check("t2_done", done_n, 1);

    // 3: N=0, L=5, abort during the 7th acceptance -> 2nd frame ends at 3 beats.
    clear_log();
    sig_ready_i = 1'b1;
    start_run(10'd5, 8'd0);
    begin
      int n = 0;
      while (ctl_busy_o && n < 200) begin
        ctl_abort_i = (acc_n == 6) && sig_valid_o && sig_ready_i;
        step();
        n++;
      end
    end
    ctl_abort_i = 1'b0;
    check("t3_timeout", ctl_busy_o, 1'b0);
    check("t3_beats", acc_n, 8);
    check("t3_last_mask", last_mask, 32'h90);
    check("t3_frame", ctl_frame_o, 8'd2);
    check("t3_done", done_n, 1);

    // 4: zero length, start+abort, start while busy, inputs changed after start.
    clear_log();
    start_run(10'd0, 8'd1);
    check("t4_len0_busy", ctl_busy_o, 1'b0);
    ctl_abort_i = 1'b1;
    start_run(10'd3, 8'd1);
    ctl_abort_i = 1'b0;
    check("t4_start_abort_busy", ctl_busy_o, 1'b0);
    sig_ready_i = 1'b0;
    start_run(10'd3, 8'd1);
    check("t4_armed_busy", ctl_busy_o, 1'b1);
    start_run(10'd7, 8'd5);
    ctl_length_i = 10'd9;
    ctl_frames_i = 8'd0;
    check("t4_still_busy", ctl_busy_o, 1'b1);
    sig_ready_i = 1'b1;
    run_until_idle("t4", 100);
    check("t4_beats", acc_n, 3);
    check("t4_last_mask", last_mask, 32'h4);
    check("t4_frame", ctl_frame_o, 8'd1);
    check("t4_done", done_n, 1);

    // 4b: abort while armed ends the run on the next cycle.
    clear_log();
    sig_ready_i = 1'b0;
    start_run(10'd2, 8'd1);
    ctl_abort_i = 1'b1;
    step();
    ctl_abort_i = 1'b0;
    check("t4b_done", ctl_done_o, 1'b1);
    step();
    check("t4b_busy", ctl_busy_o, 1'b0);
    check("t4b_frame", ctl_frame_o, 8'd0);

    // 5: asynchronous reset mid-stream, then a clean L=1 run.
    clear_log();
    sig_ready_i = 1'b1;
    start_run(10'd2, 8'd0);
    repeat (6) step();
    sig_ready_i = 1'b0;
    repeat (2) step();
    check("t5_pre_valid", sig_valid_o, 1'b1);
    check("t5_pre_frame", ctl_frame_o, 8'd1);
    check("t5_pre_drops", ctl_drops_o, 16'd2);
    #2 areset_n = 1'b0;
    #1;
    check("t5_rst_valid", sig_valid_o, 1'b0);
    check("t5_rst_last",  sig_last_o,  1'b0);
    check("t5_rst_busy",  ctl_busy_o,  1'b0);
    check("t5_rst_frame", ctl_frame_o, 8'd0);
    check("t5_rst_drops", ctl_drops_o, 16'd0);
    #3 areset_n = 1'b1;
    @(posedge sig_clock);
    #1;
    clear_log();
    sig_ready_i = 1'b1;
    start_run(10'd1, 8'd2);
    run_until_idle("t5", 100);
    check("t5_beats", acc_n, 2);
    check("t5_last_mask", last_mask, 32'h3);
    check("t5_frame", ctl_frame_o, 8'd2);
    check("t5_drops", ctl_drops_o, 16'd0);

    // 6: long stall saturates the drop counter.
    clear_log();
    sig_ready_i = 1'b1;
    start_run(10'd4, 8'd1);
    repeat (2) step();
    sig_ready_i = 1'b0;
    repeat (65534) step();
    check("t6_drops_fffe", ctl_drops_o, 16'hFFFE);
    repeat (70000 - 65534) step();
    check("t6_drops_sat", ctl_drops_o, 16'hFFFF);
    ctl_abort_i = 1'b1;
    sig_ready_i = 1'b1;
    step();
    ctl_abort_i = 1'b0;
    run_until_idle("t6", 100);
    check("t6_drops_end", ctl_drops_o, 16'hFFFF);
    check("t6_frame", ctl_frame_o, 8'd1);
    check("t6_beats", acc_n, 2);
    check("t6_last_mask", last_mask, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
